// File: rtl/rot_stage_pkg.sv
// -----------------------------------------------------------------------------
// rot_stage_pkg
// Shared types and constants for the operand staging buffer that sits in front
// of the 32-bit XOR-and-rotate datapath.
//   rot_op_t  : one rotate request {a, b, k, right}
//   ROT_OP_W  : packed width of rot_op_t (32 + 32 + 5 + 1)
//   ROT_K_W   : width of the rotate amount
// -----------------------------------------------------------------------------
package rot_stage_pkg;

    localparam int ROT_K_W  = 5;
    localparam int ROT_OP_W = 70;

    typedef struct packed {
        logic [31:0]        a;
        logic [31:0]        b;
        logic [ROT_K_W-1:0] k;
        logic               right;
    } rot_op_t;

endpackage

// File: rtl/rot_op_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// rot_op_fifo_ctrl
// Pointer and occupancy control for the operand staging FIFO. Owns the read
// and write pointers, the entry count, in_ready and the FIFO-side valid.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear, wins over push and pop
//   wr_req     : producer wants to write an entry this cycle
//   rd_req     : consumer takes the head entry this cycle
//   in_ready   : an entry may be written (not full, not flushing)
//   fifo_valid : at least one entry is stored
//   wr_ptr     : slot written on a push
//   rd_ptr     : slot of the head entry
//   count      : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module rot_op_fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             in_ready,
    output logic             fifo_valid,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic push;
    logic pop;

    // in_ready depends only on registered count and flush, so a full FIFO
    // refuses a push even when a pop happens in the same cycle.
    assign in_ready   = (count != FULL_COUNT) && !flush;
    assign fifo_valid = (count != '0);
    assign push       = wr_req && in_ready;
    assign pop        = rd_req && fifo_valid;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rot_operand_stage.sv
// -----------------------------------------------------------------------------
// rot_operand_stage
// Operand staging buffer upstream of the XOR-and-rotate datapath. Accepts
// rotate requests over valid/ready, queues up to DEPTH of them in order and
// presents the oldest to the rotator.
// Build option: define ROT_OPERAND_STAGE_BYPASS_EN to let a request reach the
// outputs combinationally when the FIFO is empty (0-cycle latency).
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   flush                           : synchronous clear of all entries
//   in_valid/in_ready               : request handshake
//   in_a, in_b, in_k, in_right      : request fields
//   out_valid/out_ready             : head handshake toward the rotator
//   out_a, out_b, out_k, out_right  : head fields, zero when out_valid = 0
//   level                           : number of stored entries
// -----------------------------------------------------------------------------
module rot_operand_stage
    import rot_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    input  logic [ROT_K_W-1:0] in_k,
    input  logic               in_right,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_a,
    output logic [31:0]        out_b,
    output logic [ROT_K_W-1:0] out_k,
    output logic               out_right,
    output logic [CNT_W-1:0]   level
);

    localparam rot_op_t ROT_OP_ZERO = rot_op_t'({ROT_OP_W{1'b0}});

    rot_op_t          mem [DEPTH];
    rot_op_t          in_op;
    rot_op_t          head_op;
    rot_op_t          sel_op;
    rot_op_t          out_op;
    logic             fifo_valid;
    logic             wr_req;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign in_op   = '{a: in_a, b: in_b, k: in_k, right: in_right};
    assign head_op = mem[rd_ptr];

`ifdef ROT_OPERAND_STAGE_BYPASS_EN
    logic bypass;

    // An empty FIFO forwards the incoming request straight through; if the
    // consumer takes it in the same cycle it is never written.
    assign bypass    = (count == '0) && in_valid && !flush;
    assign wr_req    = in_valid && !(bypass && out_ready);
    assign out_valid = fifo_valid || bypass;
    assign sel_op    = bypass ? in_op : head_op;
`else
    assign wr_req    = in_valid;
    assign out_valid = fifo_valid;
    assign sel_op    = head_op;
`endif

    rot_op_fifo_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .wr_req    (wr_req),
        .rd_req    (out_ready),
        .in_ready  (in_ready),
        .fifo_valid(fifo_valid),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Storage is deliberately not reset; count decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_req && in_ready) begin
            mem[wr_ptr] <= in_op;
        end
    end

    assign out_op    = out_valid ? sel_op : ROT_OP_ZERO;
    assign out_a     = out_op.a;
    assign out_b     = out_op.b;
    assign out_k     = out_op.k;
    assign out_right = out_op.right;
    assign level     = count;

endmodule

// File: tb/tb_rot_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_rot_operand_stage
// Directed self-checking bench for rot_operand_stage with DEPTH = 4.
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_rot_operand_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_k;
    logic        in_right;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_k;
    logic        out_right;
    logic [2:0]  level;

    int checks;
    int errors;

    rot_operand_stage #(
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_k     (in_k),
        .in_right (in_right),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_k    (out_k),
        .out_right(out_right),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] k, input logic r);
        in_valid = v;
        in_a     = a;
        in_b     = ~a;
        in_k     = k;
        in_right = r;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_a: got %h expected 0", out_a); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_push();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_00FF, 5'd4, 1'b1);
        in_b = 32'h0;
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_a !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL single_out_a: got %h expected 000000ff", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("[TB] FAIL single_out_b: got %h expected 0", out_b); end
        checks++; if (out_k !== 5'd4) begin errors++; $display("[TB] FAIL single_out_k: got %0d expected 4", out_k); end
        checks++; if (out_right !== 1'b1) begin errors++; $display("[TB] FAIL single_out_right: got %b expected 1", out_right); end
        checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("[TB] FAIL single_pop_zero: got %h expected 0", out_a); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 5'(i), 1'b0);
            checks++; if (in_ready !== (i < 4)) begin errors++; $display("[TB] FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4)); end
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL full_level: got %0d expected 4", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
        // Push while full is refused even though a pop happens in the same cycle.
        out_ready = 1'b1;
        drive(1'b1, 32'h99, 5'd9, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_a !== 32'h10) begin errors++; $display("[TB] FAIL full_head0: got %h expected 10", out_a); end
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_level: got %0d expected 3", level); end
        for (int j = 1; j < 4; j++) begin
            checks++; if (out_a !== 32'h10 + 32'(j)) begin errors++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", j, out_a, 32'h10 + 32'(j)); end
            checks++; if (out_k !== 5'(j)) begin errors++; $display("[TB] FAIL full_k[%0d]: got %0d expected %0d", j, out_k, j); end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL full_drained_level: got %0d expected 0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_drained_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 5'(i), i[0]);
`ifdef ROT_OPERAND_STAGE_BYPASS_EN
            checks++; if (out_a !== 32'(i)) begin errors++; $display("[TB] FAIL b2b_out_a[%0d]: got %h expected %h", i, out_a, 32'(i)); end
            checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_level[%0d]: got %0d expected 0", i, level); end
`else
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
                checks++; if (out_a !== 32'(i - 1)) begin errors++; $display("[TB] FAIL b2b_out_a[%0d]: got %h expected %h", i, out_a, 32'(i - 1)); end
                checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL b2b_level[%0d]: got %0d expected 1", i, level); end
            end
`endif
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
`ifndef ROT_OPERAND_STAGE_BYPASS_EN
        checks++; if (out_a !== 32'd15) begin errors++; $display("[TB] FAIL b2b_last: got %h expected f", out_a); end
        tick();
`endif
        out_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_end_level: got %0d expected 0", level); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 5'd1, 1'b0);
            tick();
        end
        flush = 1'b1;
        drive(1'b1, 32'h77, 5'd7, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
        checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL flush_level_before: got %0d expected 3", level); end
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL flush_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("[TB] FAIL flush_out_a: got %h expected 0", out_a); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready_after: got %b expected 1", in_ready); end
        drive(1'b1, 32'h55, 5'd5, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (out_a !== 32'h55) begin errors++; $display("[TB] FAIL flush_repush: got %h expected 55", out_a); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h40 + 32'(i), 5'd2, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_level: got %0d expected 0", level); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_out_a: got %h expected 0", out_a); end
        rst = 1'b0;
        drive(1'b1, 32'h66, 5'd6, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (out_a !== 32'h66) begin errors++; $display("[TB] FAIL mid_rst_push: got %h expected 66", out_a); end
        checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL mid_rst_level_after: got %0d expected 1", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b1);
`ifdef ROT_OPERAND_STAGE_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", out_valid); end
        checks++; if (out_a !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bypass_out_a: got %h expected deadbeef", out_a); end
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL bypass_level: got %0d expected 0", level); end
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nobypass_valid: got %b expected 0", out_valid); end
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        checks++; if (out_a !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL nobypass_out_a: got %h expected deadbeef", out_a); end
        checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL nobypass_level: got %0d expected 1", level); end
        tick();
`endif
        out_ready = 1'b0;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL bypass_end_level: got %0d expected 0", level); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rot_operand_stage.md
# rot_operand_stage

Operand staging buffer directly upstream of the 32-bit XOR-and-rotate datapath. Accepts rotate requests (A, B, K, direction) over a valid/ready handshake, holds up to DEPTH requests in a FIFO, and presents the oldest one to the rotator. The consumer of the rotator output supplies the ready. This decouples the request producer from result back-pressure.

## Interface
Parameters:
- DEPTH, default 4: FIFO entries; power of two, at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous clear of all entries.
- in_valid, input, 1: request present.
- in_ready, output, 1: stage can accept a request.
- in_a, input, 32: operand A.
- in_b, input, 32: operand B.
- in_k, input, 5: rotate amount.
- in_right, input, 1: 1 = rotate right, 0 = rotate left.
- out_valid, output, 1: head request presented to the rotator.
- out_ready, input, 1: the downstream result consumer takes the current request.
- out_a, output, 32: head operand A.
- out_b, output, 32: head operand B.
- out_k, output, 5: head rotate amount.
- out_right, output, 1: head direction.
- level, output, $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Push: in_valid && in_ready. The tuple is written at the write pointer.
- Pop: out_valid && out_ready. The read pointer advances.
- Both pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Count is held separately, range 0..DEPTH.
- in_ready = (count != DEPTH) && !flush.
  - Registered-state only.
  - No combinational path from out_ready.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- out_valid = (count != 0). The out_* fields come from the head entry.
- When out_valid = 0, all out_* fields are forced to 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push when empty: the entry becomes visible on out_* the next cycle.
- Flush has priority over push and pop.
  - The FIFO is empty on the next edge: count, rd_ptr and wr_ptr all go to 0.
  - A handshake in the flush cycle is discarded. in_ready = 0 during flush, so no push completes.
- Requests are never reordered, duplicated, or modified. K and direction pass through unchanged; direction handling is the rotator's job.
- No FSM beyond the count. States by count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).

## Timing
- Reset values (asynchronous, immediate on rst):
  - count = 0, rd_ptr = 0, wr_ptr = 0.
  - out_valid = 0, out_* = 0, level = 0, in_ready = 1.
  - Storage contents are not reset.
- Reset in the middle of operation drops all entries. The first push after rst deasserts is accepted on the first clk edge.
- Latency from accept to out_valid is 1 cycle (bypass disabled).
- Throughput is 1 request per cycle with out_ready held high.
- level reflects the registered count and updates on the clock edge after a push or pop.

## Configuration
- Macro ROT_OPERAND_STAGE_BYPASS_EN.
- Defined:
  - When count == 0 and in_valid = 1, out_valid = 1 and out_* = in_* combinationally.
  - If out_ready = 1 in that same cycle, the request is consumed with no write and no count change. Latency is 0 cycles.
  - If out_ready = 0, the request is written normally.
  - Flush suppresses the bypass: out_valid = 0 during flush.
- Undefined: always goes through storage, with 1-cycle latency and no in-to-out combinational path.

## Structure
- Package rot_stage_pkg holds:
  - typedef rot_op_t, a packed struct {a[31:0], b[31:0], k[4:0], right}.
  - constant ROT_OP_W = 70.
  - constant ROT_K_W = 5.
- Storage is an array of rot_op_t.
- One sub-module: rot_op_fifo_ctrl, which owns the pointers, count, in_ready and out_valid. The data array and bypass mux stay in the top level.

## Test plan
- Reset, then push A=0x0000_00FF, B=0, K=4, right=1 with out_ready=0 -> next cycle out_valid=1, out_a=0x0000_00FF, out_k=4, level=1.
- Five pushes with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th, 5th not accepted, level=4. Then pop 4 -> out_a returned in push order, in_ready=1.
- Continuous push and pop with out_ready=1, 16 requests with A=i -> one result per cycle in order, level stays at 1. Pointer wrap checked at i=4, 8, 12.
- Flush asserted with level=3 and in_valid=1 -> in_ready=0 in that cycle, next cycle level=0, out_valid=0, out_*=0.
- rst pulsed mid-stream with level=2 -> out_valid=0 and level=0 immediately, before the next clk edge. A push after release is accepted and emerges 1 cycle later.
- With ROT_OPERAND_STAGE_BYPASS_EN, empty FIFO, in_valid=1, out_ready=1, in_a=0xDEAD_BEEF -> out_a=0xDEAD_BEEF in the same cycle, level stays 0.
